// File: rtl/apb_interface_pkg.sv
// apb_interface_pkg: shared widths, FSM state type and done-matching helper
package apb_interface_pkg;
   localparam int APB_ADDR_W = 8;
   localparam int APB_DATA_W = 8;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;
   function automatic logic done_match(input logic is_wr, input logic wr_done, input logic rd_done);
      return is_wr ? wr_done : rd_done;
   endfunction
endpackage

// File: rtl/apb_interface.sv
// apb_interface: APB slave front-end turning each transfer into one strobe / done handshake
module apb_interface
   import apb_interface_pkg::*;
#(
   parameter int ADDR_W = APB_ADDR_W,
   parameter int DATA_W = APB_DATA_W
) (
   input  logic              s_apb_pclk_i,
   input  logic              s_apb_presetn_i,
   input  logic              s_apb_psel_i,
   input  logic              s_apb_penable_i,
   input  logic [ADDR_W-1:0] s_apb_paddr_i,
   input  logic              s_apb_pwrite_i,
   input  logic [DATA_W-1:0] s_apb_pwdata_i,
   output logic [DATA_W-1:0] s_apb_prdata_o,
   output logic              s_apb_pready_o,
   output logic [ADDR_W-1:0] reg_addr_o,
   output logic [DATA_W-1:0] reg_data_o,
   input  logic [DATA_W-1:0] reg_data_i,
   output logic              reg_wr_en_o,
   output logic              reg_rd_en_o,
   input  logic              reg_wr_done_i,
   input  logic              reg_rd_done_i
);
   state_t            state_q, state_d;
   logic              is_wr_q, is_wr_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] data_d, prdata_d;
   logic              wr_en_d, rd_en_d, pready_d;
   logic              setup;
   assign setup = s_apb_psel_i && !s_apb_penable_i;
   // next state and next values of every registered output
   always_comb begin
      state_d  = state_q;
      is_wr_d  = is_wr_q;
      addr_d   = reg_addr_o;
      data_d   = reg_data_o;
      prdata_d = s_apb_prdata_o;
      wr_en_d  = 1'b0;
      rd_en_d  = 1'b0;
      pready_d = 1'b0;
      case (state_q)
         IDLE: if (setup) begin
            addr_d  = s_apb_paddr_i;
            data_d  = s_apb_pwrite_i ? s_apb_pwdata_i : reg_data_o;
            is_wr_d = s_apb_pwrite_i;
            wr_en_d = s_apb_pwrite_i;
            rd_en_d = !s_apb_pwrite_i;
            state_d = WAIT;
         end
         WAIT: if (done_match(is_wr_q, reg_wr_done_i, reg_rd_done_i)) begin
            pready_d = 1'b1;
            prdata_d = is_wr_q ? s_apb_prdata_o : reg_data_i;
            state_d  = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state and output registers; reset aborts any transfer without a pready
   always_ff @(posedge s_apb_pclk_i or negedge s_apb_presetn_i) begin
      if (!s_apb_presetn_i) begin
         state_q        <= IDLE;
         is_wr_q        <= 1'b0;
         reg_addr_o     <= '0;
         reg_data_o     <= '0;
         s_apb_prdata_o <= '0;
         reg_wr_en_o    <= 1'b0;
         reg_rd_en_o    <= 1'b0;
         s_apb_pready_o <= 1'b0;
      end else begin
         state_q        <= state_d;
         is_wr_q        <= is_wr_d;
         reg_addr_o     <= addr_d;
         reg_data_o     <= data_d;
         s_apb_prdata_o <= prdata_d;
         reg_wr_en_o    <= wr_en_d;
         reg_rd_en_o    <= rd_en_d;
         s_apb_pready_o <= pready_d;
      end
   end
endmodule

// File: tb/tb_apb_interface.sv
// tb_apb_interface: table-driven APB transfers plus directed corner sequences
module tb_apb_interface;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [7:0] paddr = '0, pwdata = '0;
   logic [7:0] prdata, reg_addr, reg_wdata;
   logic [7:0] reg_rdata = '0;
   logic       pready, wr_en, rd_en;
   logic       wr_done = 1'b0, rd_done = 1'b0;
   logic       auto_rsp = 1'b0;
   int         rsp_lat = 1;
   int         total = 0, bad = 0;
   int         n_wr = 0, n_rd = 0, n_rdy = 0;
   logic [7:0] mem [256];
   typedef struct {
      logic       w;
      logic [7:0] a;
      logic [7:0] d;
      int         lat;
   } vec_t;
   vec_t tbl [10];

   apb_interface #(.ADDR_W(8), .DATA_W(8)) dut (
      .s_apb_pclk_i(clk),
      .s_apb_presetn_i(rst_n),
      .s_apb_psel_i(psel),
      .s_apb_penable_i(penable),
      .s_apb_paddr_i(paddr),
      .s_apb_pwrite_i(pwrite),
      .s_apb_pwdata_i(pwdata),
      .s_apb_prdata_o(prdata),
      .s_apb_pready_o(pready),
      .reg_addr_o(reg_addr),
      .reg_data_o(reg_wdata),
      .reg_data_i(reg_rdata),
      .reg_wr_en_o(wr_en),
      .reg_rd_en_o(rd_en),
      .reg_wr_done_i(wr_done),
      .reg_rd_done_i(rd_done)
   );

   always #5 clk = ~clk;

   // pulse counters, sampled mid-cycle
   always @(negedge clk) begin
      if (wr_en) n_wr++;
      if (rd_en) n_rd++;
      if (pready) n_rdy++;
   end

   // register block model: done rsp_lat cycles after the strobe is seen
   initial begin
      logic       w;
      logic [7:0] a, d;
      forever begin
         @(posedge clk); #1;
         if (auto_rsp) begin
            wr_done = 1'b0;
            rd_done = 1'b0;
            if (wr_en || rd_en) begin
               w = wr_en; a = reg_addr; d = reg_wdata;
               repeat (rsp_lat) begin @(posedge clk); #1; end
               if (w) begin mem[a] = d; wr_done = 1'b1; end
               else begin reg_rdata = mem[a]; rd_done = 1'b1; end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // full APB transfer; starts just after an edge, ends just after the completion edge
   task automatic apb_xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                           output int cyc, output logic [7:0] rd_val);
      psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      cyc = 1;
      while (!pready && cyc < 40) begin @(posedge clk); #1; cyc++; end
      rd_val = prdata;
      @(posedge clk); #1;
      chk("pready_single", pready, 0);
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      int         cyc, w0, r0, p0;
      logic [7:0] rd, last_rd;
      tbl[0] = '{1'b1, 8'h00, 8'h32, 1};
      tbl[1] = '{1'b0, 8'h00, 8'h32, 1};
      tbl[2] = '{1'b1, 8'h01, 8'h48, 1};
      tbl[3] = '{1'b0, 8'h01, 8'h48, 1};
      tbl[4] = '{1'b1, 8'h02, 8'h25, 1};
      tbl[5] = '{1'b0, 8'h02, 8'h25, 1};
      tbl[6] = '{1'b1, 8'h03, 8'h12, 1};
      tbl[7] = '{1'b0, 8'h03, 8'h12, 1};
      tbl[8] = '{1'b1, 8'h04, 8'h77, 5};
      tbl[9] = '{1'b0, 8'h04, 8'h77, 5};
      last_rd = 8'h00;
      // reset state
      #100;
      chk("rst_prdata", prdata, 0);
      chk("rst_pready", pready, 0);
      chk("rst_addr", reg_addr, 0);
      chk("rst_data", reg_wdata, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_rd_en", rd_en, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("idle_strobes", n_wr + n_rd + n_rdy, 0);
      // psel with penable in IDLE starts nothing
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      psel = 1'b0; penable = 1'b0;
      chk("access_in_idle", n_wr + n_rd, 0);
      // table-driven transfers
      auto_rsp = 1'b1;
      foreach (tbl[i]) begin
         rsp_lat = tbl[i].lat;
         w0 = n_wr; r0 = n_rd; p0 = n_rdy;
         apb_xfer(tbl[i].w, tbl[i].a, tbl[i].d, cyc, rd);
         if (!tbl[i].w) last_rd = tbl[i].d;
         chk("latency", cyc, 2 + tbl[i].lat);
         chk("wr_count", n_wr - w0, {31'd0, tbl[i].w});
         chk("rd_count", n_rd - r0, {31'd0, !tbl[i].w});
         chk("rdy_count", n_rdy - p0, 1);
         chk("reg_addr", reg_addr, tbl[i].a);
         if (tbl[i].w) chk("reg_data", reg_wdata, tbl[i].d);
         chk("prdata_at_ready", rd, last_rd);
         chk("prdata_after", prdata, last_rd);
      end
      // spurious read-done during a write is ignored
      auto_rsp = 1'b0;
      w0 = n_wr; p0 = n_rdy;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 8'h99;
      @(posedge clk); #1;
      chk("sp_strobe", wr_en, 1);
      penable = 1'b1; rd_done = 1'b1; reg_rdata = 8'hEE;
      @(posedge clk); #1;
      chk("sp_ready_a", pready, 0);
      @(posedge clk); #1;
      chk("sp_ready_b", pready, 0);
      rd_done = 1'b0; wr_done = 1'b1;
      @(posedge clk); #1;
      chk("sp_ready_c", pready, 1);
      wr_done = 1'b0;
      @(posedge clk); #1;
      chk("sp_ready_d", pready, 0);
      chk("sp_prdata", prdata, last_rd);
      chk("sp_counts", {n_wr - w0, n_rdy - p0}, {32'd1, 32'd1});
      psel = 1'b0; penable = 1'b0;
      // psel dropped during WAIT still completes once
      auto_rsp = 1'b1; rsp_lat = 2;
      w0 = n_wr; p0 = n_rdy;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h05; pwdata = 8'h3C;
      @(posedge clk); #1;
      psel = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("drop_wr_count", n_wr - w0, 1);
      chk("drop_rdy_count", n_rdy - p0, 1);
      rsp_lat = 1;
      apb_xfer(1'b0, 8'h05, 8'h00, cyc, rd);
      last_rd = 8'h3C;
      chk("drop_readback", rd, last_rd);
      // reset in WAIT aborts immediately
      auto_rsp = 1'b0;
      p0 = n_rdy;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 8'h55;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("abort_prdata", prdata, 0);
      chk("abort_addr", reg_addr, 0);
      chk("abort_data", reg_wdata, 0);
      chk("abort_strobes", {wr_en, rd_en, pready}, 0);
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      wr_done = 1'b1;
      @(posedge clk); #1;
      wr_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_ready", n_rdy - p0, 0);
      auto_rsp = 1'b1;
      apb_xfer(1'b1, 8'h01, 8'hA5, cyc, rd);
      chk("post_rst_lat", cyc, 3);
      chk("post_rst_prdata", rd, 0);
      apb_xfer(1'b0, 8'h01, 8'h00, cyc, rd);
      chk("post_rst_read", rd, 8'hA5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
